minv_mdiv_core: RTL and testbench

// - 256-bit prime-field modular inversion (a^-1 mod p) or modular division (b/a mod p) engine.
// - Uses the binary extended Euclidean algorithm, one step per clock.
// - Operands are loaded and results read over a 16-bit word-serial bus, least-significant word first.
// - Used as the field-inversion unit of the ECC (SM2-class) datapath.

---
 rtl/minv_mdiv_core.sv | 155 +++++++++++++++
 tb/tb_minv_mdiv_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minv_mdiv_core.sv
// minv_mdiv_core: 256-bit prime-field inversion / division engine.
// Binary extended Euclid, one step per clock, 16-bit word-serial load and read-out.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | operands load / results stream out; waits for start
// CALC   | one binary-Euclid reduction step per cycle
// DONE   | one-cycle ready pulse; result held in X1 (flag=1) or X2
module minv_mdiv_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] datain,
  input  logic        minv_mdiv,
  input  logic        minv_mdiv_en,
  input  logic        loada,
  input  logic        loadb,
  input  logic        loadp,
  input  logic        outx1,
  input  logic        outx2,
  output logic [15:0] regx1out,
  output logic [15:0] regx2out,
  output logic        minv_mdiv_rdy,
  output logic        minv_mdiv_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] a_q, a_d;
  logic [255:0] b_q, b_d;
  logic [255:0] p_q, p_d;
  logic [255:0] u_q, u_d;
  logic [255:0] v_q, v_d;
  logic [255:0] x1_q, x1_d;
  logic [255:0] x2_q, x2_d;
  logic         flag_q, flag_d;

  // x/2 mod p: odd x is made even by adding p first; the 257th bit keeps the carry.
  function automatic logic [255:0] halve_mod(input logic [255:0] x, input logic [255:0] p);
    logic [256:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    return s[256:1];
  endfunction

  // (x - y) mod p for x, y in [0,p); a borrow into bit 256 marks a negative difference.
  function automatic logic [255:0] sub_mod(input logic [255:0] x, input logic [255:0] y,
                                           input logic [255:0] p);
    logic [256:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[256]) d = d + {1'b0, p};
    return d[255:0];
  endfunction

  // State and datapath registers; everything clears on reset, aborting any CALC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state and datapath update: start beats load/shift in IDLE, one Euclid step in CALC.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    flag_d  = flag_q;

    case (state_q)
      S_IDLE: begin
        if (minv_mdiv_en) begin
          u_d     = a_q;
          v_d     = p_q;
          x1_d    = minv_mdiv ? 256'd1 : b_q;
          x2_d    = '0;
          state_d = S_CALC;
        end else begin
          if (loada)      a_d = {datain, a_q[255:16]};
          else if (loadp) p_d = {datain, p_q[255:16]};
          else if (loadb) b_d = {datain, b_q[255:16]};
          if (outx1) x1_d = {16'h0000, x1_q[255:16]};
          if (outx2) x2_d = {16'h0000, x2_q[255:16]};
        end
      end

      S_CALC: begin
        if (u_q == 256'd1) begin
          flag_d  = 1'b1;
          state_d = S_DONE;
        end else if (v_q == 256'd1) begin
          flag_d  = 1'b0;
          state_d = S_DONE;
        end else if (u_q == '0 || v_q == '0) begin
          // a shares no inverse with p: report an all-zero result
          x1_d    = '0;
          x2_d    = '0;
          flag_d  = 1'b1;
          state_d = S_DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = halve_mod(x1_q, p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = halve_mod(x2_q, p_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, p_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, p_q);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign regx1out       = x1_q[15:0];
  assign regx2out       = x2_q[15:0];
  assign minv_mdiv_rdy  = (state_q == S_DONE);
  assign minv_mdiv_flag = flag_q;

endmodule

// File: tb/tb_minv_mdiv_core.sv
// Testbench for minv_mdiv_core: table vectors, corner sequences and random operands
// checked against a Fermat-exponentiation reference model.
module tb_minv_mdiv_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] datain;
  logic        minv_mdiv, minv_mdiv_en;
  logic        loada, loadb, loadp, outx1, outx2;
  logic [15:0] regx1out, regx2out;
  logic        minv_mdiv_rdy, minv_mdiv_flag;

  minv_mdiv_core dut (
    .clk           (clk),
    .rst           (rst),
    .datain        (datain),
    .minv_mdiv     (minv_mdiv),
    .minv_mdiv_en  (minv_mdiv_en),
    .loada         (loada),
    .loadb         (loadb),
    .loadp         (loadp),
    .outx1         (outx1),
    .outx2         (outx2),
    .regx1out      (regx1out),
    .regx2out      (regx2out),
    .minv_mdiv_rdy (minv_mdiv_rdy),
    .minv_mdiv_flag(minv_mdiv_flag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] SM2_P  = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [255:0] SM2_GX = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] SM2_GY = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;

  typedef struct {
    logic [255:0] p;
    logic [255:0] a;
    logic [255:0] b;
    logic         inv;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: b * a^(p-2) mod p (Fermat), plain wide arithmetic.
  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y,
                                          input logic [255:0] p);
    logic [511:0] t;
    t = {256'd0, x} * {256'd0, y};
    t = t % {256'd0, p};
    return t[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e,
                                          input logic [255:0] p);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r, p);
      if (e[i]) r = mulmod(r, base, p);
    end
    return r;
  endfunction

  function automatic logic [255:0] model(input logic [255:0] p, input logic [255:0] a,
                                         input logic [255:0] b, input logic inv);
    logic [255:0] num;
    num = inv ? 256'd1 : b;
    return mulmod(num, powmod(a, p - 256'd2, p), p);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // which: 0 = A, 1 = B, 2 = P
  task automatic load_val(input int which, input logic [255:0] v);
    for (int w = 0; w < 16; w++) begin
      datain = v[w*16 +: 16];
      loada  = (which == 0);
      loadb  = (which == 1);
      loadp  = (which == 2);
      step();
    end
    loada = 1'b0; loadb = 1'b0; loadp = 1'b0; datain = '0;
  endtask

  task automatic start_and_read(input logic inv, input logic load_on_start,
                                output logic [255:0] res, output logic fl,
                                output int lat, output logic timeout);
    logic [255:0] r1, r2;
    int cyc;
    minv_mdiv    = inv;
    minv_mdiv_en = 1'b1;
    loada        = load_on_start;
    datain       = load_on_start ? 16'h0003 : 16'h0000;
    step();
    minv_mdiv_en = 1'b0;
    loada        = 1'b0;
    datain       = '0;
    cyc = 0;
    while (minv_mdiv_rdy !== 1'b1 && cyc < 1100) begin
      step();
      cyc++;
    end
    timeout = (minv_mdiv_rdy !== 1'b1);
    lat     = cyc + 1;
    fl      = minv_mdiv_flag;
    step();
    chk("rdy_single_pulse", 256'(minv_mdiv_rdy), 256'd0);
    outx1 = 1'b1;
    outx2 = 1'b1;
    for (int w = 0; w < 16; w++) begin
      r1[w*16 +: 16] = regx1out;
      r2[w*16 +: 16] = regx2out;
      step();
    end
    outx1 = 1'b0;
    outx2 = 1'b0;
    res = fl ? r1 : r2;
  endtask

  task automatic run_op(input logic [255:0] p, input logic [255:0] a, input logic [255:0] b,
                        input logic inv, output logic [255:0] res, output logic fl,
                        output int lat, output logic timeout);
    load_val(2, p);
    load_val(0, a);
    load_val(1, b);
    start_and_read(inv, 1'b0, res, fl, lat, timeout);
  endtask

  initial begin
    logic [255:0] res, p, a, b, e;
    logic         fl, to, inv, seen;
    int           lat;
    logic [255:0] small_p[4];

    small_p[0] = 256'd11;  small_p[1] = 256'd13;
    small_p[2] = 256'd251; small_p[3] = 256'd65521;

    tbl[0] = '{p: 256'd11, a: 256'd5,  b: 256'd0, inv: 1'b1, exp: 256'd9};
    tbl[1] = '{p: 256'd11, a: 256'd5,  b: 256'd3, inv: 1'b0, exp: 256'd5};
    tbl[2] = '{p: 256'd11, a: 256'd10, b: 256'd0, inv: 1'b1, exp: 256'd10};
    tbl[3] = '{p: 256'd13, a: 256'd2,  b: 256'd7, inv: 1'b0, exp: 256'd10};
    tbl[4] = '{p: 256'd11, a: 256'd0,  b: 256'd4, inv: 1'b1, exp: 256'd0};
    tbl[5] = '{p: 256'd65521, a: 256'd2, b: 256'd1, inv: 1'b0, exp: 256'd32761};

    rst = 1'b0; datain = '0; minv_mdiv = 1'b0; minv_mdiv_en = 1'b0;
    loada = 1'b0; loadb = 1'b0; loadp = 1'b0; outx1 = 1'b0; outx2 = 1'b0;
    #12;
    chk("reset_x1out", 256'(regx1out), 256'd0);
    chk("reset_x2out", 256'(regx2out), 256'd0);
    chk("reset_rdy",   256'(minv_mdiv_rdy), 256'd0);
    chk("reset_flag",  256'(minv_mdiv_flag), 256'd0);
    step();
    rst = 1'b1;
    step();

    // table vectors
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].inv, res, fl, lat, to);
      chk($sformatf("tbl%0d_timeout", i), 256'(to), 256'd0);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_latency_ok", i), 256'(lat <= 1040), 256'd1);
    end

    // a=1 inversion: done on the first CALC step
    run_op(256'd11, 256'd1, 256'd0, 1'b1, res, fl, lat, to);
    chk("a1_latency", 256'(lat), 256'd2);
    chk("a1_flag", 256'(fl), 256'd1);
    chk("a1_result", res, 256'd1);

    // SM2 division
    run_op(SM2_P, SM2_GX, SM2_GY, 1'b0, res, fl, lat, to);
    chk("sm2_timeout", 256'(to), 256'd0);
    chk("sm2_latency_ok", 256'(lat <= 1040), 256'd1);
    chk("sm2_result", res, model(SM2_P, SM2_GX, SM2_GY, 1'b0));
    chk("sm2_times_a", mulmod(res, SM2_GX, SM2_P), SM2_GY);

    // start wins over a simultaneous load: both runs use the original A
    load_val(2, 256'd11);
    load_val(0, 256'd5);
    start_and_read(1'b1, 1'b1, res, fl, lat, to);
    chk("startload_first", res, 256'd9);
    start_and_read(1'b1, 1'b0, res, fl, lat, to);
    chk("startload_second", res, 256'd9);

    // reset mid-CALC
    load_val(2, SM2_P);
    load_val(0, SM2_GX);
    load_val(1, SM2_GY);
    minv_mdiv = 1'b1; minv_mdiv_en = 1'b1;
    step();
    minv_mdiv_en = 1'b0;
    for (int k = 0; k < 60; k++) step();
    #2;
    rst = 1'b0;
    #1;
    chk("abort_x1out", 256'(regx1out), 256'd0);
    chk("abort_x2out", 256'(regx2out), 256'd0);
    chk("abort_rdy",   256'(minv_mdiv_rdy), 256'd0);
    chk("abort_flag",  256'(minv_mdiv_flag), 256'd0);
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (minv_mdiv_rdy) seen = 1'b1;
      step();
    end
    chk("abort_no_rdy", 256'(seen), 256'd0);
    run_op(256'd11, 256'd5, 256'd3, 1'b0, res, fl, lat, to);
    chk("after_abort_result", res, 256'd5);

    // random operands against the reference model
    for (int i = 0; i < 10; i++) begin
      p   = (i < 4) ? SM2_P : small_p[i % 4];
      a   = rnd256() % p;
      b   = rnd256() % p;
      inv = 1'($urandom_range(1, 0));
      e   = model(p, a, b, inv);
      run_op(p, a, b, inv, res, fl, lat, to);
      chk($sformatf("rnd%0d_timeout", i), 256'(to), 256'd0);
      chk($sformatf("rnd%0d_result", i), res, e);
      chk($sformatf("rnd%0d_latency_ok", i), 256'(lat <= 1040), 256'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
